speed_ramp_ctrl: RTL

//   Sits between the ALU result and the pwm block. Turns abrupt duty-code

---
 rtl/speed_ramp_if.sv | 25 ++
 rtl/speed_ramp_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/speed_ramp_if.sv
// Purpose : bundles the duty-ramp request/estop inputs and the duty/status
//           outputs of speed_ramp_ctrl into one port.
// Signals : target, target_valid, estop (master -> slave);
//           duty, busy, at_target (slave -> master).
`timescale 1ns/1ps
interface speed_ramp_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] target;
   logic             target_valid;
   logic             estop;
   logic [WIDTH-1:0] duty;
   logic             busy;
   logic             at_target;

   modport master (
      output target, target_valid, estop,
      input  duty, busy, at_target
   );

   modport slave (
      input  target, target_valid, estop,
      output duty, busy, at_target
   );
endinterface

// File: rtl/speed_ramp_ctrl.sv
// Purpose : rate-limits duty-code changes for the pwm block. The duty code
//           moves one LSB toward the requested target every STEP_CYCLES
//           clocks, and an emergency stop forces duty to 0 at once.
// Ports   : clk          system clock, rising edge
//           rst          asynchronous, active-low reset
//           bus (slave)  target/target_valid/estop in; duty/busy/at_target out
//                        (all outputs registered)
`timescale 1ns/1ps
module speed_ramp_ctrl #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned STEP_CYCLES = 256
) (
   input  logic         clk,
   input  logic         rst,
   speed_ramp_if.slave  bus
);

   localparam int unsigned CW = $clog2(STEP_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, UP, DOWN, STOP} state_t;

   state_t           state, nxt_state;
   logic [WIDTH-1:0] duty_q, nxt_duty;
   logic [WIDTH-1:0] target_q, nxt_target_q;
   logic [CW-1:0]    cnt, nxt_cnt;
   logic             busy_q, at_q;
   logic [WIDTH-1:0] eff;

   // Next-state logic; direction is recomputed from the effective target
   // every cycle so a retarget reverses the ramp without disturbing cadence.
   always_comb begin
      eff          = bus.target_valid ? bus.target : target_q;
      nxt_state    = state;
      nxt_duty     = duty_q;
      nxt_cnt      = cnt;
      nxt_target_q = eff;

      if (bus.estop) begin
         nxt_state    = STOP;
         nxt_duty     = '0;
         nxt_target_q = '0;
         nxt_cnt      = '0;
      end else begin
         case (state)
            IDLE: begin
               nxt_cnt = '0;
               if (eff > duty_q)      nxt_state = UP;
               else if (eff < duty_q) nxt_state = DOWN;
            end
            UP, DOWN: begin
               if (eff == duty_q) begin
                  nxt_state = IDLE;
                  nxt_cnt   = '0;
               end else begin
                  nxt_state = (eff > duty_q) ? UP : DOWN;
                  if (cnt == CNT_LAST) begin
                     nxt_cnt  = '0;
                     nxt_duty = (eff > duty_q) ? duty_q + WIDTH'(1)
                                               : duty_q - WIDTH'(1);
                     if (nxt_duty == eff) nxt_state = IDLE;
                  end else begin
                     nxt_cnt = cnt + CW'(1);
                  end
               end
            end
            STOP: begin
               nxt_state = IDLE;
               nxt_duty  = '0;
               nxt_cnt   = '0;
            end
            default: begin
               nxt_state = IDLE;
            end
         endcase
      end
   end

   // State and output registers; status flags follow the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         duty_q   <= '0;
         target_q <= '0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         at_q     <= 1'b1;
      end else begin
         state    <= nxt_state;
         duty_q   <= nxt_duty;
         target_q <= nxt_target_q;
         cnt      <= nxt_cnt;
         busy_q   <= (nxt_state == UP) || (nxt_state == DOWN);
         at_q     <= (nxt_state == IDLE);
      end
   end

   assign bus.duty      = duty_q;
   assign bus.busy      = busy_q;
   assign bus.at_target = at_q;

endmodule
